// File: rtl/wb_timer.sv
// -----------------------------------------------------------------------------
// wb_timer
//
// Purpose:
//   8-bit Wishbone-style slave hosting a 16-bit compare timer. The counter is
//   clocked by an 8-bit prescaler. In auto-reload mode it counts
//   0..CMP repeatedly. In one-shot mode it stops at CMP. Each compare hit
//   sets a sticky MATCH flag (write-1-to-clear), and MATCH & IE drives a
//   level interrupt.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   rst        - asynchronous, active-high reset
//   i_wb_cyc   - bus cycle request, held by the master until o_wb_ack
//   i_wb_adr   - register address (0 CTRL, 1 STATUS, 2 PSC, 3 CMP_L,
//                4 CMP_H, 5 CNT_L, 6 CNT_H, 7 reserved)
//   i_wb_we    - write enable, sampled in the ack cycle
//   i_wb_data  - write data
//   o_wb_rdt   - read data, combinational from i_wb_adr
//   o_wb_ack   - single-cycle acknowledge, one cycle after i_wb_cyc
//   irq        - level interrupt, MATCH & IE
// -----------------------------------------------------------------------------
module wb_timer #(
    parameter logic [15:0] CMP_RST = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wb_cyc,
    input  logic [2:0] i_wb_adr,
    input  logic       i_wb_we,
    input  logic [7:0] i_wb_data,
    output logic [7:0] o_wb_rdt,
    output logic       o_wb_ack,
    output logic       irq
);

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_PSC    = 3'd2;
    localparam logic [2:0] ADR_CMP_L  = 3'd3;
    localparam logic [2:0] ADR_CMP_H  = 3'd4;
    localparam logic [2:0] ADR_CNT_L  = 3'd5;
    localparam logic [2:0] ADR_CNT_H  = 3'd6;

    logic        ack_q, ack_d;
    logic        en_q, en_d;
    logic        mode_q, mode_d;
    logic        ie_q, ie_d;
    logic        match_q, match_d;
    logic [7:0]  psc_q, psc_d;
    logic [15:0] cmp_q, cmp_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  psc_cnt_q, psc_cnt_d;
    logic [7:0]  shadow_q, shadow_d;

    logic        tick;
    logic        match_set;
    logic        bus_wr;
    logic        bus_rd;

    assign bus_wr = i_wb_we & ack_q;
    assign bus_rd = ~i_wb_we & ack_q;
    assign tick   = en_q & (psc_cnt_q == psc_q);

    always_comb begin
        ack_d     = i_wb_cyc & ~ack_q;
        en_d      = en_q;
        mode_d    = mode_q;
        ie_d      = ie_q;
        match_d   = match_q;
        psc_d     = psc_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        shadow_d  = shadow_q;
        match_set = 1'b0;

        // Counting engine
        if (en_q) begin
            psc_cnt_d = tick ? 8'd0 : psc_cnt_q + 8'd1;
        end
        if (tick) begin
            if (cnt_q == cmp_q) begin
                match_set = 1'b1;
                if (mode_q) begin
                    en_d = 1'b0;
                end else begin
                    cnt_d = 16'd0;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Bus writes are applied after the engine so that they take priority
        // over the engine's effect on the same field.
        if (bus_wr) begin
            case (i_wb_adr)
                ADR_CTRL: begin
                    en_d   = i_wb_data[0];
                    mode_d = i_wb_data[1];
                    ie_d   = i_wb_data[2];
                    if (i_wb_data[3]) begin
                        // LOAD restarts the count and cancels a match from a coincident tick
                        cnt_d     = 16'd0;
                        psc_cnt_d = 8'd0;
                        match_set = 1'b0;
                    end
                end
                ADR_STATUS: begin
                    if (i_wb_data[0]) begin
                        match_d = 1'b0;
                    end
                end
                ADR_PSC:   psc_d        = i_wb_data;
                ADR_CMP_L: cmp_d[7:0]   = i_wb_data;
                ADR_CMP_H: cmp_d[15:8]  = i_wb_data;
                default: ;
            endcase
        end

        // A new match beats a simultaneous write-1-to-clear
        if (match_set) begin
            match_d = 1'b1;
        end

        // Latch the high byte when the low byte is read so a
        // CNT_L-then-CNT_H read sequence gets one consistent 16-bit value.
        if (bus_rd && (i_wb_adr == ADR_CNT_L)) begin
            shadow_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            ie_q      <= 1'b0;
            match_q   <= 1'b0;
            psc_q     <= 8'd0;
            cmp_q     <= CMP_RST;
            cnt_q     <= 16'd0;
            psc_cnt_q <= 8'd0;
            shadow_q  <= 8'd0;
        end else begin
            ack_q     <= ack_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            ie_q      <= ie_d;
            match_q   <= match_d;
            psc_q     <= psc_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            psc_cnt_q <= psc_cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        o_wb_rdt = 8'd0;
        case (i_wb_adr)
            ADR_CTRL:   o_wb_rdt = {5'd0, ie_q, mode_q, en_q};
            ADR_STATUS: o_wb_rdt = {7'd0, match_q};
            ADR_PSC:    o_wb_rdt = psc_q;
            ADR_CMP_L:  o_wb_rdt = cmp_q[7:0];
            ADR_CMP_H:  o_wb_rdt = cmp_q[15:8];
            ADR_CNT_L:  o_wb_rdt = cnt_q[7:0];
            ADR_CNT_H:  o_wb_rdt = shadow_q;
            default:    o_wb_rdt = 8'd0;
        endcase
    end

    assign o_wb_ack = ack_q;
    assign irq      = match_q & ie_q;

endmodule

// File: tb/tb_wb_timer.sv
`timescale 1ns/1ps
module tb_wb_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_wb_cyc;
    logic [2:0] i_wb_adr;
    logic       i_wb_we;
    logic [7:0] i_wb_data;
    logic [7:0] o_wb_rdt;
    logic       o_wb_ack;
    logic       irq;

    int checks = 0;
    int errors = 0;

    wb_timer #(.CMP_RST(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_adr  (i_wb_adr),
        .i_wb_we   (i_wb_we),
        .i_wb_data (i_wb_data),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Write: the commit edge is two rising edges after the call when called
    // just after a rising edge. Returns 1ns after the commit edge.
    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = a; i_wb_data = d;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_wr adr %0d: got %b expected 1", a, o_wb_ack);
        end
        i_wb_cyc = 1'b0;
        @(posedge clk); #1;
        i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = a;
        @(negedge clk);
        d = o_wb_rdt;
        i_wb_cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    // Combinational peek at a register without a bus cycle (no side effects)
    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        i_wb_adr = a;
        #1;
        d = o_wb_rdt;
    endtask

    task automatic check_regs_reset(input string tag);
        logic [7:0] v;
        logic [7:0] exp_v [8];
        exp_v = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        for (int a = 0; a < 8; a++) begin
            peek(a[2:0], v);
            checks++;
            if (v !== exp_v[a]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", tag, a, v, exp_v[a]);
            end
        end
        checks++;
        if (irq !== 1'b0 || o_wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s irq/ack: got %b/%b expected 0/0", tag, irq, o_wb_ack);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_wb_adr = 3'd0; i_wb_data = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check_regs_reset("reset");
        $display("test_reset done");
    endtask

    task automatic test_bus;
        logic [7:0] v;
        // Held cyc: ack pattern 0,1,0,1
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 3'd7;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if (o_wb_ack !== logic'(k % 2)) begin
                errors++;
                $display("FAIL ack_pattern step %0d: got %b expected %0d", k, o_wb_ack, k % 2);
            end
        end
        @(negedge clk); i_wb_cyc = 1'b0;
        @(posedge clk); #1;
        // Count to a known value then stop
        wb_write(0, 8'h08); wb_write(2, 8'h00); wb_write(3, 8'hFF); wb_write(4, 8'hFF);
        wb_write(0, 8'h01);
        repeat (8'h30) @(posedge clk); #1;
        wb_write(0, 8'h00);            // commits 0x32 edges after enable
        wb_read(5, v);
        checks++;
        if (v !== 8'h32) begin
            errors++;
            $display("FAIL stop_cnt: got %h expected 32", v);
        end
        wb_write(6, 8'hAA); wb_write(5, 8'hBB); wb_write(7, 8'hCC);
        peek(5, v);
        checks++;
        if (v !== 8'h32) begin errors++; $display("FAIL ro_cnt_l: got %h expected 32", v); end
        peek(6, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL ro_cnt_h: got %h expected 00", v); end
        peek(7, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL rsvd_rd: got %h expected 00", v); end
        $display("test_bus done");
    endtask

    task automatic test_autoreload_w1c;
        logic [7:0] v;
        wb_write(0, 8'h08); wb_write(2, 8'h00); wb_write(3, 8'h03); wb_write(4, 8'h00);
        wb_write(1, 8'h01);
        wb_write(0, 8'h05);            // enable edge E0
        repeat (3) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_e3: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_e4: got %b expected 1", irq); end
        wb_write(1, 8'h01);            // clear at E6
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr_e6: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_e7: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_e8: got %b expected 1", irq); end
        // W1C coinciding with the E12 match: set wins
        repeat (2) @(posedge clk); #1;
        wb_write(1, 8'h01);
        peek(1, v);
        checks++;
        if (v !== 8'h01 || irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_vs_set: got status %h irq %b expected 01 1", v, irq);
        end
        wb_write(1, 8'h01);            // plain clear at E14
        peek(1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL w1c_clear: got %h expected 00", v); end
        wb_write(1, 8'h00);            // E16 match sets
        wb_write(1, 8'h00);            // E18 write-0 must not clear
        peek(1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL w0_noeffect: got %h expected 01", v); end
        $display("test_autoreload_w1c done");
    endtask

    task automatic test_oneshot;
        logic [7:0] v;
        wb_write(0, 8'h08); wb_write(2, 8'h02); wb_write(3, 8'h01); wb_write(4, 8'h00);
        wb_write(1, 8'h01);
        wb_write(0, 8'h03);            // EN + one-shot
        repeat (5) @(posedge clk); #1;
        peek(1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL os_e5: got %h expected 00", v); end
        @(posedge clk); #1;
        peek(1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL os_match: got %h expected 01", v); end
        peek(0, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL os_en_off: got %h expected 02", v); end
        repeat (20) @(posedge clk); #1;
        wb_write(1, 8'h01);
        repeat (20) @(posedge clk); #1;
        peek(5, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL os_hold: got %h expected 01", v); end
        peek(1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL os_nomore: got %h expected 00", v); end
        $display("test_oneshot done");
    endtask

    task automatic test_coherent_read;
        logic [7:0] lo, hi;
        wb_write(0, 8'h08); wb_write(2, 8'h00); wb_write(3, 8'hFF); wb_write(4, 8'hFF);
        wb_write(0, 8'h01);
        repeat (16'h12FE) @(posedge clk); #1;
        wb_read(5, lo);
        wb_read(6, hi);
        checks++;
        if (lo !== 8'hFF || hi !== 8'h12) begin
            errors++;
            $display("FAIL coherent: got %h%h expected 12FF", hi, lo);
        end
        $display("test_coherent_read done");
    endtask

    task automatic test_load;
        logic [7:0] v;
        wb_write(0, 8'h08); wb_write(2, 8'h00); wb_write(3, 8'h03); wb_write(4, 8'h00);
        wb_write(1, 8'h01);
        wb_write(0, 8'h01);            // E0
        repeat (2) @(posedge clk); #1;
        wb_write(0, 8'h09);            // LOAD at the E4 match tick
        peek(1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL load_nomatch: got %h expected 00", v); end
        peek(5, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL load_cnt: got %h expected 00", v); end
        peek(0, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL load_ctrl: got %h expected 01", v); end
        repeat (4) @(posedge clk); #1;
        peek(1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL load_rematch: got %h expected 01", v); end
        $display("test_load done");
    endtask

    task automatic test_reset_midcount;
        wb_write(0, 8'h08); wb_write(2, 8'h00); wb_write(3, 8'h02); wb_write(4, 8'h00);
        wb_write(1, 8'h01);
        wb_write(0, 8'h05);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b expected 1", irq); end
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 3'd2; i_wb_data = 8'h55;
        @(posedge clk); #2;
        rst = 1'b1;                    // abort during the ack cycle
        #1;
        check_regs_reset("midrst");
        @(negedge clk); i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_regs_reset("postrst");
        $display("test_reset_midcount done");
    endtask

    task automatic test_random;
        logic [7:0] v, exp_v;
        int p, c, md, ie, n, ticks, exp_cnt, exp_match, exp_en;
        for (int t = 0; t < 12; t++) begin
            p  = $urandom_range(0, 5);
            c  = $urandom_range(0, 12);
            md = $urandom_range(0, 1);
            ie = $urandom_range(0, 1);
            n  = $urandom_range(1, 80);
            wb_write(0, 8'h00); wb_write(2, 8'(p)); wb_write(3, 8'(c)); wb_write(4, 8'h00);
            wb_write(1, 8'h01);
            wb_write(0, 8'(8 + ie * 4 + md * 2 + 1));
            repeat (n) @(posedge clk); #1;
            // Reference: one tick per PSC+1 enabled cycles; a match on every
            // (CMP+1)-th tick.
            ticks = n / (p + 1);
            if (md == 0) begin
                exp_cnt = ticks % (c + 1); exp_match = (ticks >= c + 1) ? 1 : 0; exp_en = 1;
            end else if (ticks >= c + 1) begin
                exp_cnt = c; exp_match = 1; exp_en = 0;
            end else begin
                exp_cnt = ticks; exp_match = 0; exp_en = 1;
            end
            peek(5, v);
            checks++;
            if (v !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt t%0d p%0d c%0d m%0d n%0d: got %h expected %h", t, p, c, md, n, v, 8'(exp_cnt));
            end
            peek(1, v);
            checks++;
            if (v !== 8'(exp_match)) begin
                errors++;
                $display("FAIL rnd_match t%0d: got %h expected %h", t, v, 8'(exp_match));
            end
            peek(0, v);
            exp_v = 8'(ie * 4 + md * 2 + exp_en);
            checks++;
            if (v !== exp_v) begin
                errors++;
                $display("FAIL rnd_ctrl t%0d: got %h expected %h", t, v, exp_v);
            end
            checks++;
            if (irq !== logic'(exp_match & ie)) begin
                errors++;
                $display("FAIL rnd_irq t%0d: got %b expected %0d", t, irq, exp_match & ie);
            end
            $display("rnd trial %0d: psc=%0d cmp=%0d mode=%0d ie=%0d n=%0d exp_cnt=%0d exp_match=%0d", t, p, c, md, ie, n, exp_cnt, exp_match);
        end
    endtask

    initial begin
        test_reset;
        test_bus;
        test_autoreload_w1c;
        test_oneshot;
        test_coherent_read;
        test_load;
        test_reset_midcount;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter: CMP_RST, 16'hFFFF, reset value of the compare register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_wb_cyc  input  1  bus cycle request, held until o_wb_ack.
REQ-005 i_wb_adr  input  3  register address.
REQ-006 i_wb_we  input  1  write enable, qualified by o_wb_ack.
REQ-007 i_wb_data  input  8  write data.
REQ-008 o_wb_rdt  output  8  read data, combinational from i_wb_adr.
REQ-009 o_wb_ack  output  1  one-cycle bus acknowledge.
REQ-010 irq  output  1  level interrupt, high while MATCH & IE; feeds an interrupt-controller input.

Function
REQ-011 Bus handshake: o_wb_ack <= i_wb_cyc & ~o_wb_ack; ack rises 1 cycle after cyc and lasts exactly 1 cycle.
REQ-012 Register writes occur only in the cycle where i_wb_we & o_wb_ack.
REQ-013 Register map: 0 CTRL, 1 STATUS, 2 PSC, 3 CMP_L, 4 CMP_H, 5 CNT_L, 6 CNT_H, 7 reserved.
REQ-014 CTRL: [0] EN, [1] MODE (0 auto-reload, 1 one-shot), [2] IE, [3] LOAD (write-1 strobe, reads 0), [7:4] read 0.
REQ-015 STATUS: [0] MATCH flag, write-1-to-clear, write-0 no effect; [7:1] read 0.
REQ-016 PSC: 8-bit prescaler, divisor = PSC+1; CMP_L/CMP_H form 16-bit compare CMP.
REQ-017 CNT_L/CNT_H read-only; writes ignored.
REQ-018 Read of CNT_L (ack cycle, we=0) captures cnt[15:8] into a shadow byte; CNT_H returns the shadow, giving a coherent 16-bit read.
REQ-019 Reserved address reads 0, writes ignored.
REQ-020 Prescaler: while EN, psc_cnt increments; when psc_cnt == PSC, psc_cnt <= 0 and a tick is generated that cycle; PSC = 0 ticks every cycle.
REQ-021 On tick with cnt == CMP: MATCH <= 1; MODE 0 -> cnt <= 0; MODE 1 -> cnt holds and EN <= 0.
REQ-022 On tick with cnt != CMP: cnt <= cnt + 1, wrapping 16'hFFFF -> 0 without setting MATCH.
REQ-023 Auto-reload period = (PSC+1)*(CMP+1) clock cycles between MATCH events.
REQ-024 EN = 0 freezes cnt and psc_cnt; no ticks.
REQ-025 LOAD write: cnt <= 0, psc_cnt <= 0; overrides a same-cycle tick (no MATCH from that tick); remaining CTRL bits written normally.
REQ-026 MATCH set and W1C clear in the same cycle: set wins.
REQ-027 CMP/PSC writes take effect on the next cycle; if cnt > new CMP, counter runs to wrap before matching.
REQ-028 irq = MATCH & IE, combinational from registers; clearing MATCH drops irq the next cycle, guaranteeing a fresh rising edge on the next match.

Reset
REQ-029 On rst: CTRL = 0, MATCH = 0, PSC = 0, CMP = CMP_RST, cnt = 0, psc_cnt = 0, shadow = 0, o_wb_ack = 0, irq = 0.
REQ-030 Reset mid-bus-cycle or mid-count aborts immediately; no write completes and no MATCH is retained.

Verification
REQ-031 PSC=0, CMP=3, CTRL=0x05 (EN, IE, auto-reload) -> irq rises 4 cycles after enable; after W1C clear, MATCH recurs every 4 cycles.
REQ-032 PSC=2, CMP=1, MODE=1, EN=1 -> MATCH after 6 cycles, EN reads 0, cnt holds 1, no further MATCH.
REQ-033 cnt = 0x12FF, read CNT_L (0xFF) while counter rolls to 0x1300, then read CNT_H -> 0x12.
REQ-034 W1C to STATUS in the same cycle as a match tick -> MATCH stays 1, irq stays high.
REQ-035 CTRL write 0x09 (EN+LOAD) coinciding with match tick -> cnt = 0, MATCH = 0; rst asserted mid-count -> all registers at reset values, irq = 0.
REQ-036 Bus: hold i_wb_cyc 4 cycles -> o_wb_ack toggles 0,1,0,1; write to CNT_H or address 7 -> no state change, reads return prior value / 0.
